multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Main control FSM of the multi-cycle CPU: sequences each instruction through IF/ID/EXE/MEM/WB.
//  Generates all datapath strobes, including the 2-bit PC source select that drives the PC mux
//  (00 PC+4, 01 branch target, 10 rs for jr, 11 jump address).
//  Sits between instruction register/ALU flags and the datapath; counts retired instructions.
// PARAMETERS
//  CNT_W  32  width of retired-instruction counter instr_cnt
// PORTS
//  CLK        in   1      single system clock, rising edge
//  Reset      in   1      synchronous, active-low reset (sampled on CLK rise)
//  opcode     in   6      IR[31:26], valid from ID onward
//  zero       in   1      ALU zero flag (sampled in EXE_BR)
//  sign       in   1      ALU sign flag (sampled in EXE_BR)
//  mem_ready  in   1      data-memory ready; present only with CTRL_MEM_WAIT_EN
//  PCWre      out  1      PC write enable
//  PCSrc      out  2      PC source select (encoding above)
//  IRWre      out  1      IR write enable
//  RegWre     out  1      register-file write enable
//  RegDst     out  2      00 $31, 01 rt, 10 rd
//  WrRegDSrc  out  1      0 write PC+4 (jal), 1 write DB data
//  ALUSrcB    out  1      1 extended immediate, 0 rt
//  ExtSel     out  1      0 zero-extend (ori), 1 sign-extend
//  ALUOp      out  3      000 add, 001 sub, 011 or, 100 and, 110 slt
//  mRD / mWR  out  1/1    data-memory read/write strobes
//  DBDataSrc  out  1      1 memory data, 0 ALU result
//  state      out  4      current state code
//  halted     out  1      1 while in HALT
//  instr_cnt  out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, slt 100110,
//   sw 110000, lw 110001, beq 110100, bltz 110110, j 111000, jr 111001, jal 111010, halt 111111.
//  States: IF 0000, ID 0001, EXE_AL 0110, EXE_BR 0101, EXE_LS 0010, MEM 0011, WB_AL 0111,
//   WB_LD 0100, HALT 1000. State register only; outputs are combinational from state+opcode.
//  Transitions: IF->ID always. ID: j/jal/jr->IF; halt->HALT; beq/bltz->EXE_BR->IF;
//   lw/sw->EXE_LS->MEM; sw MEM->IF; lw MEM->WB_LD->IF; ALU ops->EXE_AL->WB_AL->IF.
//   Undefined opcode: ID->IF as NOP (PCWre=1, PCSrc=00 in ID). HALT exits only via reset.
//  Latencies: j/jal/jr 2, beq/bltz 3, sw 4, ALU ops 4, lw 5 cycles.
//  PCWre=1 only in the final cycle of an instruction: ID (j/jal/jr/NOP), EXE_BR, MEM(sw),
//   WB_AL, WB_LD. Never in IF or HALT.
//  PCSrc: 11 for j/jal in ID; 10 for jr in ID; 01 in EXE_BR if (beq&zero)|(bltz&sign); else 00.
//  IRWre=1 in IF only. RegWre=1 in WB_AL, WB_LD, and ID for jal (RegDst=00, WrRegDSrc=0).
//  RegDst=10 R-type (add/sub/or/and/slt), 01 addi/ori/lw. ALUSrcB=1 addi/ori/lw/sw.
//  ExtSel=0 for ori only. ALUOp: beq/bltz use sub; lw/sw/addi use add.
//  mRD=1 in MEM for lw; mWR=1 in MEM for sw; DBDataSrc=1 in MEM/WB_LD for lw.
//  instr_cnt: +1 on each rising edge with PCWre=1; wraps 2^CNT_W-1 -> 0. HALT does not count.
//  Reset (Reset=0 at CLK rise): state<=IF, instr_cnt<=0. While Reset=0 all enables (PCWre, IRWre,
//   RegWre, mRD, mWR) forced 0, PCSrc=00, other outputs 0. Reset mid-instruction aborts it
//   with no writes; first cycle after release is IF.
// CONFIGURATION
//  CTRL_MEM_WAIT_EN defined: mem_ready port exists; MEM holds while mem_ready=0 with mRD/mWR held
//   asserted and PCWre=0; leaves on the cycle mem_ready=1 (sw: PCWre=1 that cycle).
//  Undefined: no mem_ready port; MEM always lasts exactly one cycle.
// TESTING
//  Reset low 2 cycles then high, opcode=add -> states 0,1,6,7,0; PCWre only in WB_AL; instr_cnt=1.
//  beq with zero=1 -> EXE_BR PCSrc=01 PCWre=1; repeat with zero=0 -> PCSrc=00 PCWre=1.
//  jal -> ID: PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0; next state IF.
//  lw -> 0,1,2,3,4; mRD=1 in MEM; RegWre=1, DBDataSrc=1 in WB_LD; instr_cnt +1 after WB_LD only.
//  halt -> state 1000, halted=1 for 10 cycles, instr_cnt frozen; Reset=0 -> IF, instr_cnt=0.
//  CTRL_MEM_WAIT_EN: sw with mem_ready=0 for 3 cycles -> MEM held 4 cycles, mWR=1 throughout.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle CPU main control FSM (optional CTRL_MEM_WAIT_EN adds mem_ready stall in MEM)
module multicycle_control_unit #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             sign,
`ifdef CTRL_MEM_WAIT_EN
  input  logic             mem_ready,
`endif
  output logic             PCWre,
  output logic [1:0]       PCSrc,
  output logic             IRWre,
  output logic             RegWre,
  output logic [1:0]       RegDst,
  output logic             WrRegDSrc,
  output logic             ALUSrcB,
  output logic             ExtSel,
  output logic [2:0]       ALUOp,
  output logic             mRD,
  output logic             mWR,
  output logic             DBDataSrc,
  output logic [3:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_LS = 4'b0010,
    S_MEM    = 4'b0011,
    S_WB_LD  = 4'b0100,
    S_EXE_BR = 4'b0101,
    S_EXE_AL = 4'b0110,
    S_WB_AL  = 4'b0111,
    S_HALT   = 4'b1000
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BLTZ = 6'b110110;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_mem_ready;
  logic             w_rtype;
  logic             w_imm_alu;
  logic             w_jump;
  logic             w_branch;
  logic             w_ldst;
  logic             w_known;
  logic             w_taken;

`ifdef CTRL_MEM_WAIT_EN
  assign w_mem_ready = mem_ready;
`else
  assign w_mem_ready = 1'b1;
`endif

  // Opcode class decode shared by next-state and strobe logic
  always_comb begin
    w_rtype   = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_OR) ||
                (opcode == OP_AND) || (opcode == OP_SLT);
    w_imm_alu = (opcode == OP_ADDI) || (opcode == OP_ORI);
    w_jump    = (opcode == OP_J) || (opcode == OP_JAL) || (opcode == OP_JR);
    w_branch  = (opcode == OP_BEQ) || (opcode == OP_BLTZ);
    w_ldst    = (opcode == OP_LW) || (opcode == OP_SW);
    w_known   = w_rtype || w_imm_alu || w_jump || w_branch || w_ldst || (opcode == OP_HALT);
    w_taken   = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BLTZ) && sign);
  end

  // Next-state selection; undefined opcodes retire from ID as a NOP
  always_comb begin
    w_next = S_IF;
    unique case (r_state)
      S_IF:     w_next = S_ID;
      S_ID: begin
        if (opcode == OP_HALT)           w_next = S_HALT;
        else if (w_branch)               w_next = S_EXE_BR;
        else if (w_ldst)                 w_next = S_EXE_LS;
        else if (w_rtype || w_imm_alu)   w_next = S_EXE_AL;
        else                             w_next = S_IF;
      end
      S_EXE_AL: w_next = S_WB_AL;
      S_WB_AL:  w_next = S_IF;
      S_EXE_BR: w_next = S_IF;
      S_EXE_LS: w_next = S_MEM;
      S_MEM: begin
        if (!w_mem_ready)                w_next = S_MEM;
        else if (opcode == OP_LW)        w_next = S_WB_LD;
        else                             w_next = S_IF;
      end
      S_WB_LD:  w_next = S_IF;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IF;
    endcase
  end

  // Datapath strobes from state+opcode; everything held at 0 while Reset is low
  always_comb begin
    PCWre     = 1'b0;
    PCSrc     = 2'b00;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    ALUOp     = 3'b000;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;
    state     = 4'b0000;
    halted    = 1'b0;
    instr_cnt = '0;
    if (Reset) begin
      state     = r_state;
      halted    = (r_state == S_HALT);
      instr_cnt = r_cnt;
      IRWre     = (r_state == S_IF);
      PCWre     = ((r_state == S_ID) && (w_jump || !w_known)) ||
                  (r_state == S_EXE_BR) ||
                  ((r_state == S_MEM) && (opcode == OP_SW) && w_mem_ready) ||
                  (r_state == S_WB_AL) || (r_state == S_WB_LD);
      if (r_state == S_ID) begin
        if ((opcode == OP_J) || (opcode == OP_JAL)) PCSrc = 2'b11;
        else if (opcode == OP_JR)                   PCSrc = 2'b10;
      end else if ((r_state == S_EXE_BR) && w_taken) begin
        PCSrc = 2'b01;
      end
      RegWre    = (r_state == S_WB_AL) || (r_state == S_WB_LD) ||
                  ((r_state == S_ID) && (opcode == OP_JAL));
      if (w_rtype)                                             RegDst = 2'b10;
      else if (w_imm_alu || (opcode == OP_LW))                 RegDst = 2'b01;
      WrRegDSrc = (opcode != OP_JAL);
      ALUSrcB   = w_imm_alu || w_ldst;
      ExtSel    = (opcode != OP_ORI);
      unique case (opcode)
        OP_SUB, OP_BEQ, OP_BLTZ: ALUOp = 3'b001;
        OP_OR, OP_ORI:           ALUOp = 3'b011;
        OP_AND:                  ALUOp = 3'b100;
        OP_SLT:                  ALUOp = 3'b110;
        default:                 ALUOp = 3'b000;
      endcase
      mRD       = (r_state == S_MEM) && (opcode == OP_LW);
      mWR       = (r_state == S_MEM) && (opcode == OP_SW);
      DBDataSrc = ((r_state == S_MEM) || (r_state == S_WB_LD)) && (opcode == OP_LW);
    end
  end

  // State register and retired-instruction counter
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_state <= S_IF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (PCWre) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized model-checked bench for multicycle_control_unit
module tb_multicycle_control_unit;

  localparam int CW = 4;

  localparam logic [3:0] S_IF = 4'd0, S_ID = 4'd1, S_EXE_LS = 4'd2, S_MEM = 4'd3, S_WB_LD = 4'd4;
  localparam logic [3:0] S_EXE_BR = 4'd5, S_EXE_AL = 4'd6, S_WB_AL = 4'd7, S_HALT = 4'd8;

  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR = 6'b010000, OP_AND = 6'b010001, OP_ORI = 6'b010010;
  localparam logic [5:0] OP_SLT = 6'b100110, OP_SW = 6'b110000, OP_LW = 6'b110001;
  localparam logic [5:0] OP_BEQ = 6'b110100, OP_BLTZ = 6'b110110, OP_J = 6'b111000;
  localparam logic [5:0] OP_JR = 6'b111001, OP_JAL = 6'b111010, OP_HALT = 6'b111111;

  logic          CLK = 1'b0;
  logic          Reset = 1'b0;
  logic [5:0]    opcode = 6'd0;
  logic          zero = 1'b0;
  logic          sign = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
  logic          mem_ready = 1'b1;
`endif
  logic          PCWre, IRWre, RegWre, WrRegDSrc, ALUSrcB, ExtSel, mRD, mWR, DBDataSrc, halted;
  logic [1:0]    PCSrc, RegDst;
  logic [2:0]    ALUOp;
  logic [3:0]    state;
  logic [CW-1:0] instr_cnt;

  multicycle_control_unit #(.CNT_W(CW)) dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero), .sign(sign),
`ifdef CTRL_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .RegWre(RegWre), .RegDst(RegDst),
    .WrRegDSrc(WrRegDSrc), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp),
    .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .state(state), .halted(halted),
    .instr_cnt(instr_cnt)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // expected outputs for the current cycle
  bit            e_valid = 0, e_dec = 0;
  logic          e_pcwre = 0, e_irwre, e_regwre, e_wrsrc, e_alusrcb, e_extsel, e_mrd, e_mwr, e_dbsrc, e_halted;
  logic [1:0]    e_pcsrc, e_regdst;
  logic [2:0]    e_aluop;
  logic [3:0]    e_state;
  logic [CW-1:0] e_cnt;
  logic [CW-1:0] m_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit is_rtype(input logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLT};
  endfunction

  function automatic logic [2:0] aluop_of(input logic [5:0] op);
    case (op)
      OP_SUB, OP_BEQ, OP_BLTZ: return 3'b001;
      OP_OR, OP_ORI:           return 3'b011;
      OP_AND:                  return 3'b100;
      OP_SLT:                  return 3'b110;
      default:                 return 3'b000;
    endcase
  endfunction

  // state walk of one instruction, derived from its class
  function automatic void seq_of(input logic [5:0] op, output logic [3:0] q[$]);
    q = {S_IF, S_ID};
    if (is_rtype(op) || op == OP_ADDI || op == OP_ORI) q = {q, S_EXE_AL, S_WB_AL};
    else if (op == OP_BEQ || op == OP_BLTZ)            q = {q, S_EXE_BR};
    else if (op == OP_SW)                              q = {q, S_EXE_LS, S_MEM};
    else if (op == OP_LW)                              q = {q, S_EXE_LS, S_MEM, S_WB_LD};
  endfunction

  task automatic plan(input bit rn, input logic [5:0] op, input logic [3:0] st, input bit last,
                      input bit z, input bit s);
    e_valid = 1;
    e_dec = 1;
    {e_pcwre, e_irwre, e_regwre, e_wrsrc, e_alusrcb, e_extsel, e_mrd, e_mwr, e_dbsrc, e_halted} = '0;
    e_pcsrc = 0; e_regdst = 0; e_aluop = 0; e_state = 0; e_cnt = 0;
    if (rn) begin
      e_state   = st;
      e_cnt     = m_cnt;
      e_halted  = (st == S_HALT);
      e_irwre   = (st == S_IF);
      e_pcwre   = last && st != S_IF && st != S_HALT;
      if (st == S_ID && (op == OP_J || op == OP_JAL)) e_pcsrc = 2'b11;
      else if (st == S_ID && op == OP_JR)             e_pcsrc = 2'b10;
      else if (st == S_EXE_BR && ((op == OP_BEQ && z) || (op == OP_BLTZ && s))) e_pcsrc = 2'b01;
      e_regwre  = (st == S_WB_AL) || (st == S_WB_LD) || (st == S_ID && op == OP_JAL);
      e_mrd     = (st == S_MEM) && op == OP_LW;
      e_mwr     = (st == S_MEM) && op == OP_SW;
      e_dbsrc   = (st == S_MEM || st == S_WB_LD) && op == OP_LW;
      e_dec     = (st != S_IF);
      e_regdst  = is_rtype(op) ? 2'b10 : (op inside {OP_ADDI, OP_ORI, OP_LW}) ? 2'b01 : 2'b00;
      e_wrsrc   = (op != OP_JAL);
      e_alusrcb = op inside {OP_ADDI, OP_ORI, OP_LW, OP_SW};
      e_extsel  = (op != OP_ORI);
      e_aluop   = aluop_of(op);
    end
  endtask

  // one clock: account for the edge just taken, then drive and predict the new cycle
  task automatic cyc(input bit rn, input logic [5:0] op, input logic [3:0] st, input bit last,
                     input bit z, input bit s, input bit mr);
    @(posedge CLK);
    if (!Reset) m_cnt = '0;
    else if (e_pcwre) m_cnt = m_cnt + 1'b1;
    #1;
    Reset  = rn;
    opcode = (st == S_IF) ? 6'($urandom) : op;
    zero   = z;
    sign   = s;
`ifdef CTRL_MEM_WAIT_EN
    mem_ready = mr;
`endif
    plan(rn, op, st, last, z, s);
  endtask

  // single compare process against the model
  always @(negedge CLK) begin
    if (e_valid) begin
      chk("state", 32'(state), 32'(e_state));
      chk("halted", 32'(halted), 32'(e_halted));
      chk("PCWre", 32'(PCWre), 32'(e_pcwre));
      chk("PCSrc", 32'(PCSrc), 32'(e_pcsrc));
      chk("IRWre", 32'(IRWre), 32'(e_irwre));
      chk("RegWre", 32'(RegWre), 32'(e_regwre));
      chk("mRD", 32'(mRD), 32'(e_mrd));
      chk("mWR", 32'(mWR), 32'(e_mwr));
      chk("DBDataSrc", 32'(DBDataSrc), 32'(e_dbsrc));
      chk("instr_cnt", 32'(instr_cnt), 32'(e_cnt));
      if (e_dec) begin
        chk("RegDst", 32'(RegDst), 32'(e_regdst));
        chk("WrRegDSrc", 32'(WrRegDSrc), 32'(e_wrsrc));
        chk("ALUSrcB", 32'(ALUSrcB), 32'(e_alusrcb));
        chk("ExtSel", 32'(ExtSel), 32'(e_extsel));
        chk("ALUOp", 32'(ALUOp), 32'(e_aluop));
      end
    end
  end

  task automatic run_instr(input logic [5:0] op, input int abort_k);
    logic [3:0] q[$];
    seq_of(op, q);
    for (int k = 0; k < q.size(); k++) begin
      if (k == abort_k) begin
        cyc(0, op, S_IF, 0, 0, 0, 1);
        return;
      end
`ifdef CTRL_MEM_WAIT_EN
      if (q[k] == S_MEM) begin
        repeat ($urandom_range(0, 3)) cyc(1, op, S_MEM, 0, 1'($urandom), 1'($urandom), 0);
      end
`endif
      cyc(1, op, q[k], k == q.size() - 1, 1'($urandom), 1'($urandom), 1);
    end
  endtask

  task automatic run_halt(input int n);
    cyc(1, OP_HALT, S_IF, 0, 0, 0, 1);
    cyc(1, OP_HALT, S_ID, 0, 0, 0, 1);
    repeat (n) cyc(1, OP_HALT, S_HALT, 0, 1'($urandom), 1'($urandom), 1);
    cyc(0, OP_HALT, S_IF, 0, 0, 0, 1);
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] ops [16] = '{OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLT, OP_SW,
                             OP_LW, OP_BEQ, OP_BLTZ, OP_J, OP_JR, OP_JAL, 6'b000011, 6'b101010};
    return ops[$urandom_range(0, 15)];
  endfunction

  initial begin
    // reset held two cycles: everything forced low
    cyc(0, OP_ADD, S_IF, 0, 0, 0, 1);
    cyc(0, OP_ADD, S_IF, 0, 0, 0, 1);
    @(negedge CLK); chk("rst_pcwre", 32'(PCWre), 0); chk("rst_irwre", 32'(IRWre), 0);

    // add: 0,1,6,7 then back to 0 with one retirement
    cyc(1, OP_ADD, S_IF, 0, 0, 0, 1);     @(negedge CLK); chk("add_s0", 32'(state), 0); chk("add_ir", 32'(IRWre), 1);
    cyc(1, OP_ADD, S_ID, 0, 0, 0, 1);     @(negedge CLK); chk("add_s1", 32'(state), 1); chk("add_pc1", 32'(PCWre), 0);
    cyc(1, OP_ADD, S_EXE_AL, 0, 0, 0, 1); @(negedge CLK); chk("add_s6", 32'(state), 6); chk("add_pc6", 32'(PCWre), 0);
    cyc(1, OP_ADD, S_WB_AL, 1, 0, 0, 1);  @(negedge CLK); chk("add_s7", 32'(state), 7); chk("add_pc7", 32'(PCWre), 1);

    // jal retires in ID
    cyc(1, OP_JAL, S_IF, 0, 0, 0, 1);     @(negedge CLK); chk("add_cnt", 32'(instr_cnt), 1); chk("jal_if", 32'(state), 0);
    cyc(1, OP_JAL, S_ID, 1, 0, 0, 1);     @(negedge CLK);
    chk("jal_pcwre", 32'(PCWre), 1); chk("jal_pcsrc", 32'(PCSrc), 3); chk("jal_regwre", 32'(RegWre), 1);
    chk("jal_regdst", 32'(RegDst), 0); chk("jal_wrsrc", 32'(WrRegDSrc), 0);

    // beq taken then not taken
    cyc(1, OP_BEQ, S_IF, 0, 0, 0, 1);     @(negedge CLK); chk("jal_next_if", 32'(state), 0);
    cyc(1, OP_BEQ, S_ID, 0, 0, 0, 1);
    cyc(1, OP_BEQ, S_EXE_BR, 1, 1, 0, 1); @(negedge CLK);
    chk("beq_t_state", 32'(state), 5); chk("beq_t_pcsrc", 32'(PCSrc), 1); chk("beq_t_pcwre", 32'(PCWre), 1);
    cyc(1, OP_BEQ, S_IF, 0, 0, 0, 1);
    cyc(1, OP_BEQ, S_ID, 0, 0, 0, 1);
    cyc(1, OP_BEQ, S_EXE_BR, 1, 0, 1, 1); @(negedge CLK);
    chk("beq_n_pcsrc", 32'(PCSrc), 0); chk("beq_n_pcwre", 32'(PCWre), 1);

    // halt holds with the counter frozen, reset clears it
    cyc(1, OP_HALT, S_IF, 0, 0, 0, 1);
    cyc(1, OP_HALT, S_ID, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(1, OP_HALT, S_HALT, 0, 0, 0, 1); @(negedge CLK);
      chk("halt_state", 32'(state), 8); chk("halt_flag", 32'(halted), 1); chk("halt_cnt", 32'(instr_cnt), 4);
    end
    cyc(0, OP_HALT, S_IF, 0, 0, 0, 1);
    cyc(1, OP_ADD, S_IF, 0, 0, 0, 1); @(negedge CLK);
    chk("post_halt_state", 32'(state), 0); chk("post_halt_cnt", 32'(instr_cnt), 0);
    cyc(1, OP_ADD, S_ID, 0, 0, 0, 1);
    cyc(1, OP_ADD, S_EXE_AL, 0, 0, 0, 1);
    cyc(1, OP_ADD, S_WB_AL, 1, 0, 0, 1);

`ifdef CTRL_MEM_WAIT_EN
    // sw stalled three cycles in MEM
    cyc(1, OP_SW, S_IF, 0, 0, 0, 1);
    cyc(1, OP_SW, S_ID, 0, 0, 0, 1);
    cyc(1, OP_SW, S_EXE_LS, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, OP_SW, S_MEM, 0, 0, 0, 0); @(negedge CLK);
      chk("sw_wait_state", 32'(state), 3); chk("sw_wait_mwr", 32'(mWR), 1); chk("sw_wait_pcwre", 32'(PCWre), 0);
    end
    cyc(1, OP_SW, S_MEM, 1, 0, 0, 1); @(negedge CLK);
    chk("sw_done_mwr", 32'(mWR), 1); chk("sw_done_pcwre", 32'(PCWre), 1);
`endif

    // randomized instruction stream with occasional aborts and halts
    for (int n = 0; n < 300; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 4) run_halt(int'($urandom_range(1, 5)));
      else run_instr(pick_op(), (r < 12) ? int'($urandom_range(0, 4)) : -1);
    end

    @(posedge CLK);
    #1 e_valid = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
